// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan controller: blank pattern,
// board-clock timing defaults and the active-low hex glyph table.
package seg_scan_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // 50 MHz board clock: 1 kHz per digit, 10 us anti-ghost gap.
  localparam int DIV_DEFAULT   = 50000;
  localparam int BLANK_DEFAULT = 500;

  // Active-low glyphs, bit order g..a.
  localparam logic [6:0] HEX_0 = 7'h40;
  localparam logic [6:0] HEX_1 = 7'h79;
  localparam logic [6:0] HEX_2 = 7'h24;
  localparam logic [6:0] HEX_3 = 7'h30;
  localparam logic [6:0] HEX_4 = 7'h19;
  localparam logic [6:0] HEX_5 = 7'h12;
  localparam logic [6:0] HEX_6 = 7'h02;
  localparam logic [6:0] HEX_7 = 7'h78;
  localparam logic [6:0] HEX_8 = 7'h00;
  localparam logic [6:0] HEX_9 = 7'h10;
  localparam logic [6:0] HEX_A = 7'h08;
  localparam logic [6:0] HEX_B = 7'h03;
  localparam logic [6:0] HEX_C = 7'h46;
  localparam logic [6:0] HEX_D = 7'h21;
  localparam logic [6:0] HEX_E = 7'h06;
  localparam logic [6:0] HEX_F = 7'h0E;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = HEX_0;
      4'h1: pat = HEX_1;
      4'h2: pat = HEX_2;
      4'h3: pat = HEX_3;
      4'h4: pat = HEX_4;
      4'h5: pat = HEX_5;
      4'h6: pat = HEX_6;
      4'h7: pat = HEX_7;
      4'h8: pat = HEX_8;
      4'h9: pat = HEX_9;
      4'hA: pat = HEX_A;
      4'hB: pat = HEX_B;
      4'hC: pat = HEX_C;
      4'hD: pat = HEX_D;
      4'hE: pat = HEX_E;
      default: pat = HEX_F;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_if.sv
// Load port and display outputs of seg_scan. load is a one-cycle strobe with
// no ready: every edge that sees load = 1 accepts data_in/dp_in/en_in.
interface seg_scan_if #(
  parameter int DIGITS    = 8,
  parameter int IDX_WIDTH = 3
);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     en_in;
  logic [IDX_WIDTH-1:0]  digit_idx;
  logic [7:0]            seg_n;
  logic                  frame_done;
  logic                  pending;

  modport master (
    output load, data_in, dp_in, en_in,
    input  digit_idx, seg_n, frame_done, pending
  );

  modport slave (
    input  load, data_in, dp_in, en_in,
    output digit_idx, seg_n, frame_done, pending
  );
endinterface

// File: rtl/seg_scan_hex7.sv
// Combinational hex nibble to active-low seven-segment glyph (g..a).
module seg_hex7
  import seg_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = hex7(nib_i);
endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit seven-segment scanner with frame-aligned
// double-buffered display data and registered outputs.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int IDX_WIDTH = 3,
  parameter int DIV       = DIV_DEFAULT,
  parameter int BLANK     = BLANK_DEFAULT,
  parameter int CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  seg_scan_if.slave   bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DIV - 1);
  localparam logic [CNT_WIDTH-1:0] BLANK_C  = CNT_WIDTH'(BLANK);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(DIGITS - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [4*DIGITS-1:0]  stg_data_q, stg_data_d, dsp_data_q, dsp_data_d;
  logic [DIGITS-1:0]    stg_dp_q, stg_dp_d, dsp_dp_q, dsp_dp_d;
  logic [DIGITS-1:0]    stg_en_q, stg_en_d, dsp_en_q, dsp_en_d;
  logic                 pend_q, pend_d;
  logic [7:0]           seg_q, seg_d;
  logic                 fd_q, fd_d;

  logic                 dwell_end, wrap;
  logic [3:0]           nib;
  logic                 dp_bit, en_bit;
  logic [6:0]           glyph;

  always_comb begin
    dwell_end = (cnt_q == CNT_LAST);
    wrap      = dwell_end && (idx_q == IDX_LAST);
    cnt_d     = dwell_end ? '0 : cnt_q + CNT_WIDTH'(1);
    idx_d     = dwell_end ? idx_q + IDX_WIDTH'(1) : idx_q;
    fd_d      = wrap;
  end

  // Display registers only change on a wrap edge; a load landing on that
  // same edge skips staging so it is shown in the frame that starts now.
  always_comb begin
    stg_data_d = stg_data_q;
    stg_dp_d   = stg_dp_q;
    stg_en_d   = stg_en_q;
    dsp_data_d = dsp_data_q;
    dsp_dp_d   = dsp_dp_q;
    dsp_en_d   = dsp_en_q;
    pend_d     = pend_q;
    if (wrap) begin
      if (bus.load) begin
        dsp_data_d = bus.data_in;
        dsp_dp_d   = bus.dp_in;
        dsp_en_d   = bus.en_in;
      end else if (pend_q) begin
        dsp_data_d = stg_data_q;
        dsp_dp_d   = stg_dp_q;
        dsp_en_d   = stg_en_q;
      end
      pend_d = 1'b0;
    end else if (bus.load) begin
      stg_data_d = bus.data_in;
      stg_dp_d   = bus.dp_in;
      stg_en_d   = bus.en_in;
      pend_d     = 1'b1;
    end
  end

  // The segment register is fed from next-state values so seg_n and
  // digit_idx always describe the same post-edge dwell.
  always_comb begin
    nib = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d == IDX_WIDTH'(k)) nib = dsp_data_d[4*k +: 4];
    end
    dp_bit = dsp_dp_d[idx_d];
    en_bit = dsp_en_d[idx_d];
  end

  seg_hex7 u_hex7 (
    .nib_i (nib),
    .seg_o (glyph)
  );

  always_comb begin
    if ((cnt_d < BLANK_C) || !en_bit) seg_d = SEG_OFF;
    else                              seg_d = {~dp_bit, glyph};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      stg_data_q <= '0;
      stg_dp_q   <= '0;
      stg_en_q   <= '0;
      dsp_data_q <= '0;
      dsp_dp_q   <= '0;
      dsp_en_q   <= '0;
      pend_q     <= 1'b0;
      seg_q      <= SEG_OFF;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stg_data_q <= stg_data_d;
      stg_dp_q   <= stg_dp_d;
      stg_en_q   <= stg_en_d;
      dsp_data_q <= dsp_data_d;
      dsp_dp_q   <= dsp_dp_d;
      dsp_en_q   <= dsp_en_d;
      pend_q     <= pend_d;
      seg_q      <= seg_d;
      fd_q       <= fd_d;
    end
  end

  assign bus.digit_idx  = idx_q;
  assign bus.seg_n      = seg_q;
  assign bus.frame_done = fd_q;
  assign bus.pending    = pend_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan (DIV=4, BLANK=1) with a frame-arithmetic
// reference model checked every cycle plus hand-computed spot values.
module tb_seg_scan;
  localparam int DIGITS = 8;
  localparam int IDXW   = 3;
  localparam int DIV    = 4;
  localparam int BLANK  = 1;
  localparam int FRAME  = DIGITS * DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seg_scan_if #(.DIGITS(DIGITS), .IDX_WIDTH(IDXW)) bus ();

  seg_scan #(
    .DIGITS(DIGITS), .IDX_WIDTH(IDXW), .DIV(DIV), .BLANK(BLANK), .CNT_WIDTH(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Glyph table written out independently of the RTL package.
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: n = clock edges since reset release; everything else derives from it.
  int          n;
  logic [31:0] sh_data, st_data;
  logic [7:0]  sh_dp, sh_en, st_dp, st_en;
  bit          pend, fd_exp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; pend = 0; fd_exp = 0;
      sh_data = '0; sh_dp = '0; sh_en = '0;
      st_data = '0; st_dp = '0; st_en = '0;
    end else begin
      n++;
      fd_exp = (n % FRAME == 0);
      if (fd_exp) begin
        if (bus.load) begin
          sh_data = bus.data_in; sh_dp = bus.dp_in; sh_en = bus.en_in;
        end else if (pend) begin
          sh_data = st_data; sh_dp = st_dp; sh_en = st_en;
        end
        pend = 0;
      end else if (bus.load) begin
        st_data = bus.data_in; st_dp = bus.dp_in; st_en = bus.en_in;
        pend = 1;
      end
    end
  end

  function automatic logic [7:0] exp_seg();
    int ph = n % DIV;
    int d  = (n / DIV) % DIGITS;
    logic [3:0] nb;
    if (ph < BLANK || !sh_en[d]) return 8'hFF;
    nb = sh_data[d*4 +: 4];
    return {~sh_dp[d], hex_tab[nb]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (n=%0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_idx",     32'(bus.digit_idx),  32'((n / DIV) % DIGITS));
      check("model_seg",     32'(bus.seg_n),      32'(exp_seg()));
      check("model_frame",   32'(bus.frame_done), 32'(fd_exp));
      check("model_pending", 32'(bus.pending),    32'(pend));
    end
  end

  // Advance to the negedge where the model edge count equals target.
  task automatic goto(input int target);
    int b = 0;
    while (n != target && b < 5000) begin
      @(negedge clk);
      b++;
    end
    checks++;
    if (n != target) begin
      errors++;
      $display("FAIL goto: reached n=%0d expected n=%0d", n, target);
    end
  endtask

  task automatic do_load(input int at_edge, input logic [31:0] d,
                         input logic [7:0] dp, input logic [7:0] en);
    goto(at_edge - 1);
    bus.load = 1'b1; bus.data_in = d; bus.dp_in = dp; bus.en_in = en;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  initial begin
    bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.en_in = '0;
    #1 rst = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_idx",  32'(bus.digit_idx),  32'h0);
    check("rst_seg",  32'(bus.seg_n),      32'hFF);
    check("rst_pend", 32'(bus.pending),    32'h0);
    check("rst_fd",   32'(bus.frame_done), 32'h0);
    rst = 1'b0;

    goto(3);  check("adv_not_yet", 32'(bus.digit_idx), 32'h0);
    goto(4);  check("adv_first",   32'(bus.digit_idx), 32'h1);

    // Load coincident with a wrap edge.
    do_load(32, 32'h76543210, 8'h01, 8'hFF);
    check("wrap_fd",     32'(bus.frame_done), 32'h1);
    check("wrap_blank",  32'(bus.seg_n),      32'hFF);
    check("wrap_pend",   32'(bus.pending),    32'h0);
    goto(33); check("d0_glyph",  32'(bus.seg_n), 32'h40);
              check("fd_one_cy", 32'(bus.frame_done), 32'h0);
    goto(37); check("d1_glyph",  32'(bus.seg_n), 32'hF9);
    goto(64); check("fd_next",   32'(bus.frame_done), 32'h1);

    // Deferred commit while digit 3 is being shown.
    do_load(77, 32'hFFFFFFFF, 8'h00, 8'hFF);
    check("defer_pend",  32'(bus.pending), 32'h1);
    goto(78); check("defer_old", 32'(bus.seg_n), 32'hB0);
    goto(96); check("commit_pend", 32'(bus.pending), 32'h0);
    goto(97); check("commit_d0", 32'(bus.seg_n), 32'h8E);

    // Digit 0 disabled.
    do_load(128, 32'h76543210, 8'h00, 8'hFE);
    goto(129); check("dis_d0_a", 32'(bus.seg_n), 32'hFF);
    goto(131); check("dis_d0_b", 32'(bus.seg_n), 32'hFF);
    goto(133); check("dis_d1",   32'(bus.seg_n), 32'hF9);

    // Async reset mid-dwell with data staged.
    do_load(150, 32'h12345678, 8'hFF, 8'hFF);
    check("stage_pend", 32'(bus.pending), 32'h1);
    goto(155);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("arst_idx",  32'(bus.digit_idx), 32'h0);
    check("arst_seg",  32'(bus.seg_n),     32'hFF);
    check("arst_pend", 32'(bus.pending),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    goto(33); check("dark_seg",  32'(bus.seg_n),   32'hFF);
              check("dark_pend", 32'(bus.pending), 32'h0);
    goto(70);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
